oled_frame_buffer: RTL and testbench
====================================

// Module: oled_frame_buffer
// PURPOSE
//  1024-byte display frame buffer (128x64 mono, page-major) feeding the I2C LCD controller.
//  Answers the controller's lcd_address with lcd_data.
//  Host port accepts pixel set/clear/toggle (read-modify-write), byte writes and full-buffer fills.
// PARAMETERS
//  FB_W      128   display width in pixels (x range 0..127)
//  FB_PAGES  8     number of 8-row pages (y range 0..63)
//  FB_BYTES  1024  FB_W*FB_PAGES; RAM depth per bank
// PORTS
//  reset        in   1   asynchronous, active-low
//  clk2         in   1   clock (same clk2 as the I2C controller)
//  lcd_address  in   10  byte index requested by controller
//  lcd_data     out  8   registered byte at lcd_address
//  pix_valid    in   1   host op request
//  pix_ready    out  1   op accepted when pix_valid&pix_ready
//  pix_op       in   2   00 set, 01 clear, 10 toggle, 11 byte write
//  pix_x        in   7   column 0..127
//  pix_y        in   6   row 0..63; byte write uses pix_y[5:3] only
//  pix_byte     in   8   data for byte write
//  clr_req      in   1   fill request (sampled in IDLE only)
//  clr_pattern  in   8   fill byte, captured on accept
//  clr_busy     out  1   high while a fill is in progress
//  swap_req     in   1   request bank swap (FB_DBUF_EN only)
//  swap_done    out  1   1-cycle pulse when swap occurs
// BEHAVIOUR
//  - Reset: state IDLE; lcd_data=8'h00, clr_busy=0, swap_done=0, disp_bank=0, swap_pend=0.
//    RAM is not cleared. Reset mid-fill aborts; bytes already written keep the pattern.
//  - Address map: addr = {pix_y[5:3], pix_x}; bit = pix_y[2:0]. Bit 0 is the top row of the page.
//  - Display read: lcd_data <= ram[lcd_address] every cycle; 1-cycle latency.
//    Same-cycle host write to that address: lcd_data returns the old byte (read-before-write).
//  - pix_ready = (state==IDLE) & ~clr_req. clr_req wins over a pending pixel op.
//  - FSM IDLE->RD->WR->IDLE for set/clear/toggle:
//    - Accept at cycle N, RAM read N+1, write (old|m, old&~m, old^m) N+2, IDLE at N+3.
//    - Throughput is 1 op per 3 cycles.
//  - Byte write: IDLE->WR->IDLE. Writes pix_byte; 2 cycles.
//  - FSM IDLE->CLR on clr_req:
//    - Walks addr 0..1023 one byte/cycle with clr_pattern; clr_busy high all 1024 cycles.
//    - Returns to IDLE after addr 1023. The walk counter is 10 bits and its terminal value is 1023.
//    - clr_req while busy is ignored.
//  - Only 3 bits of pix_y participate in bit select; pix_x/pix_y are never out of range by width.
//  - Host op parameters are captured on accept; later input changes do not affect the op in flight.
// CONFIGURATION
//  FB_DBUF_EN defined:
//  - 2 banks (2048x8). Display reads bank disp_bank; host ops and fills target ~disp_bank.
//  - swap_req (any cycle) sets swap_pend.
//  - Swap occurs on the cycle lcd_address changes 1023->0 (compare with registered previous address):
//    disp_bank toggles, swap_pend clears, swap_done pulses.
//  - If swap_req and the swap boundary fall in the same cycle, the swap is taken and swap_pend ends 0.
//  - No swap while state!=IDLE. The swap is deferred to the next frame boundary.
//  FB_DBUF_EN undefined:
//  - Single bank, shared by display and host.
//  - swap_req ignored; swap_done tied 0.
// STRUCTURE
//  fb_pkg: FB_W, FB_PAGES, FB_BYTES, op codes OP_SET/OP_CLR/OP_TGL/OP_BYTE, state enum IDLE/RD/WR/CLR.
//  Sub-module fb_ram_dp: dual-port RAM.
//  - Port A: sync read (display).
//  - Port B: sync read + write (host).
//  - Depth FB_BYTES or 2*FB_BYTES.
// TESTING
//  1 Reset then byte write x=5,y=8,byte=8'hA5 -> lcd_address=133 gives lcd_data=8'hA5 next cycle.
//  2 Byte 8'h00 at addr 0, then set x=0,y=3 -> 8'h08; toggle y=3 -> 8'h00. Check pix_ready low 2 cycles per op.
//  3 clr_req, pattern 8'hFF -> clr_busy high exactly 1024 cycles; every address reads 8'hFF.
//    pix_valid during the fill is not accepted.
//  4 clr_req and pix_valid same cycle in IDLE -> fill accepted, pixel op held until fill done.
//  5 Host write addr 200 same cycle lcd_address=200 -> lcd_data old value, then new value next read.
//  6 FB_DBUF_EN: writes to back bank are invisible. swap_req, then lcd_address 1023->0 -> swap_done pulse.
//    Back-bank data appears; second swap_req before the boundary gives one swap only.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, op codes and FSM state type for the OLED frame buffer.
// Double buffering is selected by defining FB_DBUF_EN.
package fb_pkg;

  localparam int FB_W     = 128;
  localparam int FB_PAGES = 8;
  localparam int FB_BYTES = FB_W * FB_PAGES;
  localparam int FB_AW    = 10;

  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_BYTES - 1);

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_TGL  = 2'b10;
  localparam logic [1:0] OP_BYTE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    CLR  = 2'd3
  } fb_state_t;

  // Page-major layout: each byte holds 8 vertically stacked pixels of one column.
  function automatic logic [FB_AW-1:0] pix_addr(input logic [6:0] x, input logic [5:0] y);
    return {y[5:3], x};
  endfunction

  function automatic logic [7:0] bit_mask(input logic [2:0] b);
    return 8'b1 << b;
  endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// Dual-port frame RAM: port A is a read-only display port, port B is the host read/write port.
// Both reads are registered and return the pre-write contents on an address collision.
module fb_ram_dp #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk2,
  input  logic          reset,
  input  logic [AW-1:0] a_addr,
  output logic [7:0]    a_data,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk2) begin
    if (b_we) mem[b_addr] <= b_wdata;
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      a_data  <= 8'h00;
      b_rdata <= 8'h00;
    end else begin
      a_data  <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/oled_frame_buffer.sv
// 128x64 mono frame buffer serving the LCD controller and a pixel/byte/fill host port.
// Define FB_DBUF_EN for a front/back bank pair swapped at the frame boundary.
module oled_frame_buffer
  import fb_pkg::*;
(
  input  logic       reset,
  input  logic       clk2,
  input  logic [9:0] lcd_address,
  output logic [7:0] lcd_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [1:0] pix_op,
  input  logic [6:0] pix_x,
  input  logic [5:0] pix_y,
  input  logic [7:0] pix_byte,
  input  logic       clr_req,
  input  logic [7:0] clr_pattern,
  output logic       clr_busy,
  input  logic       swap_req,
  output logic       swap_done
);

`ifdef FB_DBUF_EN
  localparam int RAM_AW = FB_AW + 1;
`else
  localparam int RAM_AW = FB_AW;
`endif

  fb_state_t state_q, state_d;

  logic [FB_AW-1:0] addr_q;
  logic [2:0]       bit_q;
  logic [1:0]       op_q;
  logic [7:0]       byte_q;
  logic [7:0]       pattern_q;
  logic [FB_AW-1:0] clr_cnt;

  logic [FB_AW-1:0]  host_addr;
  logic [RAM_AW-1:0] a_addr;
  logic [RAM_AW-1:0] b_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [7:0]        mask;

  assign pix_ready = (state_q == IDLE) && !clr_req;
  assign clr_busy  = (state_q == CLR);

  // Host op parameters are frozen at accept so the op in flight ignores later input changes.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bit_q     <= '0;
      op_q      <= OP_SET;
      byte_q    <= 8'h00;
      pattern_q <= 8'h00;
      clr_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (clr_req) begin
          pattern_q <= clr_pattern;
          clr_cnt   <= '0;
        end else if (pix_valid) begin
          addr_q <= pix_addr(pix_x, pix_y);
          bit_q  <= pix_y[2:0];
          op_q   <= pix_op;
          byte_q <= pix_byte;
        end
      end else if (state_q == CLR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    host_addr = addr_q;
    ram_wdata = byte_q;
    mask      = bit_mask(bit_q);
    case (state_q)
      IDLE: begin
        if (clr_req)        state_d = CLR;
        else if (pix_valid) state_d = (pix_op == OP_BYTE) ? WR : RD;
      end
      RD: state_d = WR;
      WR: begin
        ram_we = 1'b1;
        case (op_q)
          OP_SET:  ram_wdata = ram_rdata | mask;
          OP_CLR:  ram_wdata = ram_rdata & ~mask;
          OP_TGL:  ram_wdata = ram_rdata ^ mask;
          default: ram_wdata = byte_q;
        endcase
        state_d = IDLE;
      end
      CLR: begin
        ram_we    = 1'b1;
        host_addr = clr_cnt;
        ram_wdata = pattern_q;
        if (clr_cnt == LAST_ADDR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FB_DBUF_EN
  logic [FB_AW-1:0] prev_addr;
  logic             disp_bank;
  logic             swap_pend;
  logic             swap_now;

  // The first byte of the new frame already comes from the newly displayed bank.
  assign swap_now = (prev_addr == LAST_ADDR) && (lcd_address == '0) &&
                    (swap_pend || swap_req) && (state_q == IDLE);
  assign a_addr   = {disp_bank ^ swap_now, lcd_address};
  assign b_addr   = {~disp_bank, host_addr};

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      prev_addr <= '0;
      disp_bank <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      prev_addr <= lcd_address;
      swap_done <= swap_now;
      if (swap_now) begin
        disp_bank <= ~disp_bank;
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end
`else
  logic swap_unused;

  assign swap_unused = swap_req;
  assign swap_done   = 1'b0;
  assign a_addr      = lcd_address;
  assign b_addr      = host_addr;
`endif

  fb_ram_dp #(
    .AW    (RAM_AW),
    .DEPTH (1 << RAM_AW)
  ) u_ram (
    .clk2    (clk2),
    .reset   (reset),
    .a_addr  (a_addr),
    .a_data  (lcd_data),
    .b_addr  (b_addr),
    .b_we    (ram_we),
    .b_wdata (ram_wdata),
    .b_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_oled_frame_buffer.sv
// Directed self-checking bench for oled_frame_buffer; the FB_DBUF_EN build runs the bank-swap scenario.
module tb_oled_frame_buffer;
  import fb_pkg::*;

  logic       reset;
  logic       clk2;
  logic [9:0] lcd_address;
  logic [7:0] lcd_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [1:0] pix_op;
  logic [6:0] pix_x;
  logic [5:0] pix_y;
  logic [7:0] pix_byte;
  logic       clr_req;
  logic [7:0] clr_pattern;
  logic       clr_busy;
  logic       swap_req;
  logic       swap_done;

  int n_checks = 0;
  int n_fail   = 0;

  oled_frame_buffer dut (
    .reset       (reset),
    .clk2        (clk2),
    .lcd_address (lcd_address),
    .lcd_data    (lcd_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_op      (pix_op),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_byte    (pix_byte),
    .clr_req     (clr_req),
    .clr_pattern (clr_pattern),
    .clr_busy    (clr_busy),
    .swap_req    (swap_req),
    .swap_done   (swap_done)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [6:0] x, input logic [5:0] y,
                       input logic [7:0] b, output int lat);
    int guard = 0;
    pix_op = op; pix_x = x; pix_y = y; pix_byte = b; pix_valid = 1'b1;
    while (!pix_ready && guard < 2000) begin guard++; tick(); end
    tick();
    pix_valid = 1'b0; pix_x = ~x; pix_y = ~y; pix_byte = ~b; pix_op = ~op;
    lat = 0;
    while (!pix_ready && lat < 10) begin lat++; tick(); end
  endtask

  task automatic read_addr(input logic [9:0] a, output logic [7:0] d);
    lcd_address = a;
    tick();
    d = lcd_data;
  endtask

  task automatic boundary();
    lcd_address = 10'd1023;
    tick();
    lcd_address = 10'd0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; lcd_address = '0; pix_valid = 1'b0; pix_op = OP_SET; pix_x = '0; pix_y = '0;
    pix_byte = 8'h00; clr_req = 1'b0; clr_pattern = 8'h00; swap_req = 1'b0;
    #12;
    n_checks++; if (lcd_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_lcd_data: got %h expected 00", lcd_data); end
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clr_busy: got %b expected 0", clr_busy); end
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_swap_done: got %b expected 0", swap_done); end
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_pix_ready: got %b expected 1", pix_ready); end
    @(negedge clk2);
    reset = 1'b1;
    tick();
  endtask

`ifndef FB_DBUF_EN
  task automatic test_byte_write();
    int lat;
    logic [7:0] d;
    do_op(OP_BYTE, 7'd5, 6'd8, 8'hA5, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL byte_ready_low: got %0d cycles expected 1", lat); end
    read_addr(10'd133, d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("[TB] FAIL byte_write_133: got %h expected a5", d); end
    do_op(OP_BYTE, 7'd127, 6'd63, 8'h3C, lat);
    read_addr(10'd1023, d);
    n_checks++; if (d !== 8'h3C) begin n_fail++; $display("[TB] FAIL byte_write_1023: got %h expected 3c", d); end
  endtask

  task automatic test_pixel_ops();
    logic [1:0] ops [6] = '{OP_SET, OP_TGL, OP_SET, OP_SET, OP_CLR, OP_TGL};
    logic [5:0] ys  [6] = '{6'd3, 6'd3, 6'd7, 6'd0, 6'd7, 6'd0};
    logic [7:0] exps[6] = '{8'h08, 8'h00, 8'h80, 8'h81, 8'h01, 8'h00};
    int lat;
    logic [7:0] d;
    do_op(OP_BYTE, 7'd0, 6'd0, 8'h00, lat);
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], 7'd0, ys[i], 8'hFF, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL pixel_ready_low[%0d]: got %0d cycles expected 2", i, lat); end
      read_addr(10'd0, d);
      n_checks++; if (d !== exps[i]) begin n_fail++; $display("[TB] FAIL pixel_result[%0d]: got %h expected %h", i, d, exps[i]); end
    end
    do_op(OP_BYTE, 7'd127, 6'd56, 8'h00, lat);
    do_op(OP_SET, 7'd127, 6'd63, 8'h00, lat);
    read_addr(10'd1023, d);
    n_checks++; if (d !== 8'h80) begin n_fail++; $display("[TB] FAIL pixel_corner: got %h expected 80", d); end
  endtask

  task automatic test_fill();
    int busy_cycles = 0;
    int ready_bad = 0;
    int errs = 0;
    clr_pattern = 8'hFF; clr_req = 1'b1;
    tick();
    clr_req = 1'b0; clr_pattern = 8'h00;
    pix_op = OP_CLR; pix_x = 7'd0; pix_y = 6'd0; pix_valid = 1'b1;
    while (clr_busy && busy_cycles < 2000) begin
      busy_cycles++;
      if (pix_ready) ready_bad++;
      tick();
    end
    pix_valid = 1'b0;
    n_checks++; if (busy_cycles !== 1024) begin n_fail++; $display("[TB] FAIL fill_busy_cycles: got %0d expected 1024", busy_cycles); end
    n_checks++; if (ready_bad !== 0) begin n_fail++; $display("[TB] FAIL fill_ready_blocked: got %0d ready cycles expected 0", ready_bad); end
    tick();
    for (int i = 0; i < 1024; i++) begin
      lcd_address = 10'(i);
      tick();
      if (lcd_data !== 8'hFF) errs++;
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("[TB] FAIL fill_readback: got %0d bad bytes expected 0", errs); end
  endtask

  task automatic test_clr_priority();
    int waits = 0;
    logic [7:0] d;
    clr_pattern = 8'h3C; clr_req = 1'b1;
    pix_op = OP_BYTE; pix_x = 7'd10; pix_y = 6'd0; pix_byte = 8'h77; pix_valid = 1'b1;
    tick();
    clr_req = 1'b0;
    n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_fill_taken: got %b expected 1", clr_busy); end
    while (!pix_ready && waits < 2000) begin waits++; tick(); end
    n_checks++; if (waits !== 1024) begin n_fail++; $display("[TB] FAIL prio_op_held: got %0d cycles expected 1024", waits); end
    tick();
    pix_valid = 1'b0;
    tick();
    read_addr(10'd10, d);
    n_checks++; if (d !== 8'h77) begin n_fail++; $display("[TB] FAIL prio_op_done: got %h expected 77", d); end
    read_addr(10'd11, d);
    n_checks++; if (d !== 8'h3C) begin n_fail++; $display("[TB] FAIL prio_fill_data: got %h expected 3c", d); end
  endtask

  task automatic test_read_before_write();
    lcd_address = 10'd200;
    pix_op = OP_BYTE; pix_x = 7'd72; pix_y = 6'd8; pix_byte = 8'h5A; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    n_checks++; if (lcd_data !== 8'h3C) begin n_fail++; $display("[TB] FAIL rbw_old: got %h expected 3c", lcd_data); end
    tick();
    n_checks++; if (lcd_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL rbw_new: got %h expected 5a", lcd_data); end
  endtask

  task automatic test_swap_disabled();
    logic [7:0] d;
    swap_req = 1'b1;
    tick();
    boundary();
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("[TB] FAIL swap_disabled: got %b expected 0", swap_done); end
    swap_req = 1'b0;
    read_addr(10'd200, d);
    n_checks++; if (d !== 8'h5A) begin n_fail++; $display("[TB] FAIL single_bank_kept: got %h expected 5a", d); end
  endtask
`else
  task automatic run_fill(input logic [7:0] p, output int cycles);
    clr_pattern = p; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cycles = 0;
    while (clr_busy && cycles < 2000) begin cycles++; tick(); end
  endtask

  task automatic test_dbuf();
    int cycles;
    int lat;
    logic [7:0] d;
    run_fill(8'h22, cycles);
    n_checks++; if (cycles !== 1024) begin n_fail++; $display("[TB] FAIL dbuf_fill_cycles: got %0d expected 1024", cycles); end
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    boundary();
    n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("[TB] FAIL first_swap_done: got %b expected 1", swap_done); end
    tick();
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("[TB] FAIL swap_pulse_width: got %b expected 0", swap_done); end
    read_addr(10'd7, d);
    n_checks++; if (d !== 8'h22) begin n_fail++; $display("[TB] FAIL front_after_swap: got %h expected 22", d); end

    clr_pattern = 8'h11; clr_req = 1'b1; tick(); clr_req = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    boundary();
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("[TB] FAIL no_swap_in_fill: got %b expected 0", swap_done); end
    cycles = 0;
    while (clr_busy && cycles < 2000) begin cycles++; tick(); end
    read_addr(10'd7, d);
    n_checks++; if (d !== 8'h22) begin n_fail++; $display("[TB] FAIL back_fill_hidden: got %h expected 22", d); end
    boundary();
    n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("[TB] FAIL deferred_swap: got %b expected 1", swap_done); end
    read_addr(10'd7, d);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("[TB] FAIL deferred_data: got %h expected 11", d); end

    do_op(OP_BYTE, 7'd5, 6'd8, 8'hA5, lat);
    read_addr(10'd133, d);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("[TB] FAIL byte_hidden: got %h expected 11", d); end
    swap_req = 1'b1; tick(); swap_req = 1'b0; tick(); swap_req = 1'b1; tick(); swap_req = 1'b0;
    boundary();
    n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("[TB] FAIL requested_swap: got %b expected 1", swap_done); end
    read_addr(10'd133, d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("[TB] FAIL back_byte_shown: got %h expected a5", d); end
    read_addr(10'd134, d);
    n_checks++; if (d !== 8'h22) begin n_fail++; $display("[TB] FAIL back_neighbor: got %h expected 22", d); end
    boundary();
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_swap_only: got %b expected 0", swap_done); end

    lcd_address = 10'd1023; tick();
    lcd_address = 10'd0; swap_req = 1'b1; tick(); swap_req = 1'b0;
    n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("[TB] FAIL same_cycle_swap: got %b expected 1", swap_done); end
    boundary();
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_cleared: got %b expected 0", swap_done); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FB_DBUF_EN
    test_byte_write();
    test_pixel_ops();
    test_fill();
    test_clr_priority();
    test_read_before_write();
    test_swap_disabled();
`else
    test_dbuf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
